// File: rtl/bcd_stopwatch_core.sv
// Purpose : DIGITS-wide BCD stopwatch/timer with up/down count, preset load and lap capture.
// Latency : every output is registered; commands take effect on the edge after they are sampled.
// Backpr. : none; single-cycle command pulses, at most one count step per TICK_DIV cycles.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start, stop          single-cycle pulses entering RUNNING / STOPPED (stop wins)
//   dir                  0 = count up, 1 = count down (sampled on each tick)
//   load, load_value     preset count (nibbles > 9 clamp to 9), forces STOPPED
//   lap                  capture pre-update count into lap_value
//   count                current BCD value, digit 0 in [3:0]
//   running              high in RUNNING
//   wrap                 one-cycle pulse on up-count rollover all-9 -> all-0
//   done                 one-cycle pulse when a down-count reaches 0
//   lap_value, lap_valid last captured count and its one-cycle update strobe
//
// Build option: define STOPWATCH_LAP_EN to build the lap register; otherwise
// lap is ignored and lap_value / lap_valid are tied to 0.

module bcd_stopwatch_core #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  wrap,
    output logic                  done,
    output logic [4*DIGITS-1:0]   lap_value,
    output logic                  lap_valid
);

    localparam int            W       = 4 * DIGITS;
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_count;
    logic [W-1:0]    w_count_nxt;
    logic [PW-1:0]   r_pre;
    logic [PW-1:0]   w_pre_nxt;
    logic            r_wrap;
    logic            r_done;
    logic            w_wrap_nxt;
    logic            w_done_nxt;

    logic [W-1:0]    w_count_inc;
    logic [W-1:0]    w_count_dec;
    logic [W-1:0]    w_load_clamped;
    logic            w_inc_carry;
    logic            w_dec_borrow;
    logic            w_count_zero;
    logic            w_tick;

    assign w_count_zero = (r_count == '0);
    assign w_tick       = (r_pre == PRE_MAX);

    // Ripple BCD increment; carry out of the top digit means all-9 rolled to all-0.
    always_comb begin
        w_count_inc = r_count;
        w_inc_carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_inc_carry) begin
                if (r_count[4*d +: 4] >= 4'd9) begin
                    w_count_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_inc_carry           = 1'b0;
                end
            end
        end
    end

    // Ripple BCD decrement; a 0 digit becomes 9 and borrows from the next one.
    always_comb begin
        w_count_dec  = r_count;
        w_dec_borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_dec_borrow) begin
                if (r_count[4*d +: 4] == 4'd0) begin
                    w_count_dec[4*d +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                    w_dec_borrow          = 1'b0;
                end
            end
        end
    end

    // Non-decimal preset nibbles saturate to 9 so the register always holds valid BCD.
    always_comb begin
        w_load_clamped = load_value;
        for (int d = 0; d < DIGITS; d++) begin
            if (load_value[4*d +: 4] > 4'd9) begin
                w_load_clamped[4*d +: 4] = 4'd9;
            end
        end
    end

    // Command priority load > stop > start; a tick only advances when no command is present.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pre_nxt   = r_pre;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = w_load_clamped;
            w_pre_nxt   = '0;
            w_state_nxt = ST_STOPPED;
        end else if (stop) begin
            // Prescaler holds so a later restart resumes the same phase.
            w_state_nxt = ST_STOPPED;
        end else if (r_state == ST_STOPPED) begin
            // Counting down from zero would underflow; refuse to start.
            if (start && !(dir && w_count_zero)) begin
                w_state_nxt = ST_RUNNING;
            end
        end else if (w_tick) begin
            w_pre_nxt = '0;
            if (dir) begin
                w_count_nxt = w_count_dec;
                if (w_count_dec == '0) begin
                    w_state_nxt = ST_STOPPED;
                    w_done_nxt  = 1'b1;
                end
            end else begin
                w_count_nxt = w_count_inc;
                w_wrap_nxt  = w_inc_carry;
            end
        end else begin
            w_pre_nxt = r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_pre   <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_pre   <= w_pre_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count   = r_count;
    assign running = (r_state == ST_RUNNING);
    assign wrap    = r_wrap;
    assign done    = r_done;

`ifdef STOPWATCH_LAP_EN
    logic [W-1:0] r_lap_value;
    logic         r_lap_valid;

    // Captures the register value before any same-cycle load or tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lap_value <= '0;
            r_lap_valid <= 1'b0;
        end else begin
            r_lap_valid <= lap;
            if (lap) begin
                r_lap_value <= r_count;
            end
        end
    end

    assign lap_value = r_lap_value;
    assign lap_valid = r_lap_valid;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign lap_value    = '0;
    assign lap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Purpose : directed scoreboard bench for bcd_stopwatch_core (DIGITS=4, TICK_DIV=4).
// Latency : each expected output event carries the cycle it must appear on.
// Backpr. : none; the monitor pops one expectation per observed output event.

module tb_bcd_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        lap = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        wrap;
    logic        done;
    logic [15:0] lap_value;
    logic        lap_valid;

    bcd_stopwatch_core #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .lap        (lap),
        .count      (count),
        .running    (running),
        .wrap       (wrap),
        .done       (done),
        .lap_value  (lap_value),
        .lap_valid  (lap_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] cnt;
        logic        run;
        logic        wr;
        logic        dn;
        logic        lv;
        logic [15:0] lval;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push_exp(input int c, input logic [15:0] cnt, input logic run,
                            input logic wr, input logic dn, input logic lv,
                            input logic [15:0] lval);
        exp_t e;
        e.c = c; e.cnt = cnt; e.run = run; e.wr = wr; e.dn = dn; e.lv = lv; e.lval = lval;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r      = 16'h0000;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Monitor: any change of count/running, or any pulse output, is one event.
    logic [16:0] prev_obs = '0;
    exp_t        m_e;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_obs = {count, running};
        end else begin
            if ({count, running} != prev_obs || wrap || done || lap_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: cyc=%0d count=%h run=%b wrap=%b done=%b lapv=%b lap=%h, required no event",
                             cyc, count, running, wrap, done, lap_valid, lap_value);
                end else begin
                    m_e = sb.pop_front();
                    if (m_e.c != cyc || m_e.cnt != count || m_e.run != running || m_e.wr != wrap ||
                        m_e.dn != done || m_e.lv != lap_valid || m_e.lval != lap_value) begin
                        n_errors++;
                        $display("FAIL event: got cyc=%0d count=%h run=%b wrap=%b done=%b lapv=%b lap=%h, required cyc=%0d count=%h run=%b wrap=%b done=%b lapv=%b lap=%h",
                                 cyc, count, running, wrap, done, lap_valid, lap_value,
                                 m_e.c, m_e.cnt, m_e.run, m_e.wr, m_e.dn, m_e.lv, m_e.lval);
                    end
                end
            end
            prev_obs = {count, running};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    int b;
    logic [15:0] lap_a;
    logic [15:0] lap_b;

    initial begin
        lap_a = LAP ? 16'h0042 : 16'h0000;
        lap_b = LAP ? 16'h0043 : 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_count",     32'(count),     32'h0);
        chk("rst_running",   32'(running),   32'h0);
        chk("rst_wrap",      32'(wrap),      32'h0);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_lap_value", 32'(lap_value), 32'h0);
        chk("rst_lap_valid", 32'(lap_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Free run up: ten ticks in 40 cycles, first one 4 cycles after the start edge.
        b = cyc;
        start = 1'b1;
        push_exp(b + 1, 16'h0000, 1, 0, 0, 0, 16'h0);
        for (int i = 1; i <= 10; i++) push_exp(b + 1 + 4 * i, to_bcd(i), 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 42); stop = 1'b1;
        push_exp(b + 43, 16'h0010, 0, 0, 0, 0, 16'h0);
        @(negedge clk); stop = 1'b0;
        do_reset();

        // Up-count rollover with a single-cycle wrap.
        b = cyc;
        load = 1'b1; load_value = 16'h9998; dir = 1'b0;
        push_exp(b + 1, 16'h9998, 0, 0, 0, 0, 16'h0);
        @(negedge clk); load = 1'b0; start = 1'b1;
        push_exp(b + 2, 16'h9998, 1, 0, 0, 0, 16'h0);
        push_exp(b + 6, 16'h9999, 1, 0, 0, 0, 16'h0);
        push_exp(b + 10, 16'h0000, 1, 1, 0, 0, 16'h0);
        push_exp(b + 14, 16'h0001, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 15); stop = 1'b1;
        push_exp(b + 16, 16'h0001, 0, 0, 0, 0, 16'h0);
        @(negedge clk); stop = 1'b0;
        do_reset();

        // Down-count terminal: done pulse, auto stop, later start ignored at zero.
        b = cyc;
        load = 1'b1; load_value = 16'h0002; dir = 1'b1;
        push_exp(b + 1, 16'h0002, 0, 0, 0, 0, 16'h0);
        @(negedge clk); load = 1'b0; start = 1'b1;
        push_exp(b + 2, 16'h0002, 1, 0, 0, 0, 16'h0);
        push_exp(b + 6, 16'h0001, 1, 0, 0, 0, 16'h0);
        push_exp(b + 10, 16'h0000, 0, 0, 1, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 12); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 20);
        dir = 1'b0;
        do_reset();

        // Stop on a tick cycle, start+stop together, restart resumes prescaler phase.
        b = cyc;
        start = 1'b1;
        push_exp(b + 1, 16'h0000, 1, 0, 0, 0, 16'h0);
        push_exp(b + 5, 16'h0001, 1, 0, 0, 0, 16'h0);
        push_exp(b + 9, 16'h0002, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 12); stop = 1'b1;
        push_exp(b + 13, 16'h0002, 0, 0, 0, 0, 16'h0);
        @(negedge clk); stop = 1'b0;
        wait_cyc(b + 15); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        wait_cyc(b + 18); start = 1'b1;
        push_exp(b + 19, 16'h0002, 1, 0, 0, 0, 16'h0);
        push_exp(b + 20, 16'h0003, 1, 0, 0, 0, 16'h0);
        push_exp(b + 24, 16'h0004, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 25); stop = 1'b1;
        push_exp(b + 26, 16'h0004, 0, 0, 0, 0, 16'h0);
        @(negedge clk); stop = 1'b0;
        do_reset();

        // Clamped load while stopped and while running; load clears the prescaler.
        b = cyc;
        load = 1'b1; load_value = 16'h1A3F;
        push_exp(b + 1, 16'h1939, 0, 0, 0, 0, 16'h0);
        @(negedge clk); load = 1'b0;
        wait_cyc(b + 2); start = 1'b1;
        push_exp(b + 3, 16'h1939, 1, 0, 0, 0, 16'h0);
        push_exp(b + 7, 16'h1940, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 8); load = 1'b1;
        push_exp(b + 9, 16'h1939, 0, 0, 0, 0, 16'h0);
        @(negedge clk); load = 1'b0;
        wait_cyc(b + 10); start = 1'b1;
        push_exp(b + 11, 16'h1939, 1, 0, 0, 0, 16'h0);
        push_exp(b + 15, 16'h1940, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 16); stop = 1'b1;
        push_exp(b + 17, 16'h1940, 0, 0, 0, 0, 16'h0);
        @(negedge clk); stop = 1'b0;
        do_reset();

        // Lap on a tick cycle, then lap together with load captures the pre-load value.
        b = cyc;
        load = 1'b1; load_value = 16'h0041;
        push_exp(b + 1, 16'h0041, 0, 0, 0, 0, 16'h0);
        @(negedge clk); load = 1'b0; start = 1'b1;
        push_exp(b + 2, 16'h0041, 1, 0, 0, 0, 16'h0);
        push_exp(b + 6, 16'h0042, 1, 0, 0, 0, 16'h0);
        @(negedge clk); start = 1'b0;
        wait_cyc(b + 9); lap = 1'b1;
        push_exp(b + 10, 16'h0043, 1, 0, 0, LAP, lap_a);
        @(negedge clk); lap = 1'b0;
        wait_cyc(b + 11); stop = 1'b1;
        push_exp(b + 12, 16'h0043, 0, 0, 0, 0, lap_a);
        @(negedge clk); stop = 1'b0;
        wait_cyc(b + 13); load = 1'b1; load_value = 16'h0100; lap = 1'b1;
        push_exp(b + 14, 16'h0100, 0, 0, 0, LAP, lap_b);
        @(negedge clk); load = 1'b0; lap = 1'b0;
        wait_cyc(b + 18);

        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_core.md
# bcd_stopwatch_core

Parametrised multi-digit BCD stopwatch/timer core, the next generation of the timer datapath: replaces the fixed four-counter, up-only chain with a DIGITS-wide BCD register. It adds count-down with terminal stop, a synchronous preset load, and lap capture. It sits between the debounced button front end and the 7-segment scanner, driving the scanner's digit bus directly.

## Interface
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS
- TICK_DIV, 100000, clk cycles per count tick (>= 2); 100000 at 100 MHz gives 1 kHz
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain only
- start  in  1  single-cycle pulse, enter RUNNING
- stop  in  1  single-cycle pulse, enter STOPPED
- dir  in  1  0 = count up, 1 = count down; sampled on each tick
- load  in  1  single-cycle pulse, preset count from load_value
- load_value  in  4*DIGITS  BCD preset, digit 0 in [3:0]
- lap  in  1  single-cycle pulse, capture count into lap_value
- count  out  4*DIGITS  current BCD value
- running  out  1  high in RUNNING
- wrap  out  1  one-cycle pulse on up-count rollover all-9 -> all-0
- done  out  1  one-cycle pulse when down-count reaches 0
- lap_value  out  4*DIGITS  last captured count
- lap_valid  out  1  one-cycle pulse, lap_value updated

## Operation
- States: STOPPED (reset state), RUNNING. No other states.
- Reset: count = 0, lap_value = 0, prescaler = 0, state STOPPED; running, wrap, done, lap_valid all 0.
- Per-cycle command priority: reset > load > stop > start. lap is independent of these commands and evaluated alongside them.
- load: count <= load_value with each nibble > 9 clamped to 9. Prescaler cleared. State forced to STOPPED, including when load arrives while running.
- stop: state to STOPPED. Prescaler holds its value; it is not cleared.
- start in STOPPED: enter RUNNING. Exception: dir=1 with count==0, where start is ignored and the block stays STOPPED. start while already RUNNING has no effect.
- start and stop in the same cycle: stop wins.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING. tick is asserted internally when the prescaler equals TICK_DIV-1, and the prescaler returns to 0 on that cycle.
- Up tick: BCD ripple increment. A digit that was 9 becomes 0 and carries to the next digit. All-9 becomes all-0, wrap pulses, and the block stays RUNNING.
- Down tick: BCD ripple decrement. A digit that was 0 becomes 9 and borrows from the next digit.
  - If the result is 0, the state goes to STOPPED and done pulses.
  - Down tick with count already 0 cannot occur, because of the start guard and the load-forces-STOPPED rule.
- dir change while running takes effect at the next tick only.
- tick coincident with stop or load: the command wins and count does not advance.
- lap: lap_value <= the count register value before any same-cycle update; lap_valid pulses. lap is legal in either state.
- lap in the same cycle as load captures the pre-load value.

## Timing
- All outputs are registered.
- count, wrap and done change on the same edge. wrap/done are high for exactly the cycle in which count shows the new value.
- running rises on the edge after start and falls on the edge after stop, or with the count edge for a down-count terminal.
- First tick comes TICK_DIV cycles after the start edge when the prescaler starts at 0. After stop/start, the prescaler resumes from its held value, so no partial period is lost.
- lap_value and lap_valid update 1 cycle after lap.
- Load result is visible 1 cycle after load.
- Throughput: at most one count step per TICK_DIV cycles.

## Configuration
- STOPWATCH_LAP_EN defined: lap register and lap_valid are built as described above.
- STOPWATCH_LAP_EN undefined: no lap logic is built.
  - lap input is ignored.
  - lap_value is tied to 0 and lap_valid to 0.
  - Port list is unchanged.

## Test plan
Run with DIGITS=4, TICK_DIV=4 for simulation.
- Reset, start, run 40 cycles -> count 0x0010; running=1; the first increment lands 4 cycles after the start edge.
- load 0x9998, dir=0, start, 8 cycles -> count 0x9999, then 0x0000 with wrap high for exactly 1 cycle; running stays 1.
- load 0x0002, dir=1, start -> count 0x0001, then 0x0000 with done pulse; running=0. A following start is ignored and count stays 0x0000.
- Running, stop asserted on a tick cycle -> count does not advance. start+stop in the same cycle -> STOPPED. Restart resumes the prescaler phase.
- load_value 0x1A3F -> count 0x1939 with running=0, including when load is issued during RUNNING.
- With STOPWATCH_LAP_EN, lap at count 0x0042 on a tick cycle -> lap_value 0x0042 and lap_valid for 1 cycle, while count becomes 0x0043. Without the macro, lap_valid stays 0 and lap_value stays 0x0000.
